// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_MIPS32 issue/interlock logic and decode.
//   REG_AW      : register-address width
//   tk_entry_t  : one destination-tracker slot {valid, rd}
//   OP_*        : 6-bit primary opcodes used by decode
package mips32_pkg;

  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } tk_entry_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Empty tracker slot (bubble / stall / squashed op).
  function automatic tk_entry_t tk_none();
    return '{valid: 1'b0, rd: '0};
  endfunction

endpackage

// File: rtl/mips32_dest_tracker.sv
// Destination tracker: one slot per pipeline stage after ID (EX, MEM, WB).
// Shifts every cycle; reports a RAW hazard for two source-register compare
// ports and whether every slot is empty.
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_push               : entry entering tk[0] this edge
//   i_kill               : forces tk[0] invalid this edge (taken-branch squash)
//   i_use_a/i_reg_a      : compare port A (rs)
//   i_use_b/i_reg_b      : compare port B (rt)
//   o_hazard             : a source matches an in-flight destination
//   o_empty              : no valid slot anywhere
module mips32_dest_tracker
  import mips32_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned WB_BYPASS  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  tk_entry_t         i_push,
  input  logic              i_kill,
  input  logic              i_use_a,
  input  logic [REG_AW-1:0] i_reg_a,
  input  logic              i_use_b,
  input  logic [REG_AW-1:0] i_reg_b,
  output logic              o_hazard,
  output logic              o_empty
);

  // Slots at or beyond this index are already written back (or being
  // written in the first half-cycle) and cannot cause a hazard.
  localparam int unsigned HAZ_SLOTS = PIPE_DEPTH - WB_BYPASS;

  tk_entry_t r_tk [PIPE_DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        r_tk[i] <= tk_none();
      end
    end else begin
      r_tk[0] <= i_kill ? tk_none() : i_push;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        r_tk[i] <= r_tk[i-1];
      end
    end
  end

  logic w_hazard;
  logic w_empty;

  always_comb begin
    w_hazard = 1'b0;
    w_empty  = 1'b1;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (r_tk[i].valid) begin
        w_empty = 1'b0;
        if (i < HAZ_SLOTS) begin
          // R0 is hard-wired zero, so reads of it never depend on anything.
          if ((i_use_a && (i_reg_a != '0) && (r_tk[i].rd == i_reg_a)) ||
              (i_use_b && (i_reg_b != '0) && (r_tk[i].rd == i_reg_b))) begin
            w_hazard = 1'b1;
          end
        end
      end
    end
  end

  assign o_hazard = w_hazard;
  assign o_empty  = w_empty;

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Issue/interlock controller at ID of the 5-stage pipe_MIPS32 datapath.
// Stalls on RAW hazards (no forwarding), blocks issue behind an unresolved
// branch, squashes on a taken branch and sequences HLT until drained.
//   i_clk, i_rst_n                  : clock, synchronous active-low reset
//   i_id_valid                      : ID holds a valid instruction
//   i_id_rs/rt, i_id_use_rs/rt      : source registers and their use flags
//   i_id_wr_en, i_id_rd             : destination write enable / register
//   i_id_is_branch, i_id_is_halt    : BEQZ/BNEQZ, HLT
//   i_br_resolve, i_br_taken        : oldest pending branch resolved (pulse)
//   o_issue, o_stall                : ID->EX advance / held (combinational)
//   o_flush                         : squash IF/ID and ID/EX (registered)
//   o_halted                        : sticky halt (registered)
//   o_stall_cnt                     : saturating stall-cycle counter
module mips32_hazard_ctrl
  import mips32_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned WB_BYPASS  = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic              i_id_wr_en,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_is_branch,
  input  logic              i_id_is_halt,
  input  logic              i_br_resolve,
  input  logic              i_br_taken,
  output logic              o_issue,
  output logic              o_stall,
  output logic              o_flush,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic             r_branch_pend;
  logic             r_halt_pend;
  logic             r_halted;
  logic             r_flush;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_hazard;
  logic             w_empty;
  logic             w_issue;
  logic             w_stall;
  logic             w_br_taken;
  tk_entry_t        w_push;

  logic             w_branch_pend_nxt;
  logic             w_halt_pend_nxt;
  logic             w_halted_nxt;
  logic             w_flush_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;

  mips32_dest_tracker #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .WB_BYPASS  (WB_BYPASS)
  ) u_tracker (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (w_push),
    .i_kill   (w_br_taken),
    .i_use_a  (i_id_use_rs),
    .i_reg_a  (i_id_rs),
    .i_use_b  (i_id_use_rt),
    .i_reg_b  (i_id_rt),
    .o_hazard (w_hazard),
    .o_empty  (w_empty)
  );

  // Gating issue with i_rst_n keeps the datapath quiet while reset is held.
  assign w_issue = i_rst_n & i_id_valid & ~w_hazard & ~r_branch_pend &
                   ~r_halt_pend & ~r_halted & ~r_flush;
  assign w_stall = i_rst_n & i_id_valid & ~w_issue;

  // Writes to R0 are discarded by the register file, so they are not tracked.
  assign w_push = '{valid: w_issue & i_id_wr_en & (i_id_rd != '0), rd: i_id_rd};

  // Resolve pulses with nothing pending are stray and ignored.
  assign w_br_taken = i_br_resolve & i_br_taken & r_branch_pend;

  always_comb begin
    w_branch_pend_nxt = r_branch_pend;
    w_halt_pend_nxt   = r_halt_pend;
    w_halted_nxt      = r_halted;
    w_flush_nxt       = w_br_taken;
    w_stall_cnt_nxt   = r_stall_cnt;

    if (i_br_resolve) begin
      w_branch_pend_nxt = 1'b0;
    end
    // Issue is blocked while a branch is pending, so set and clear never collide.
    if (w_issue && i_id_is_branch) begin
      w_branch_pend_nxt = 1'b1;
    end
    if (w_issue && i_id_is_halt) begin
      w_halt_pend_nxt = 1'b1;
    end
    if (r_halt_pend && w_empty) begin
      w_halted_nxt = 1'b1;
    end
    if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      w_stall_cnt_nxt = r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_branch_pend <= 1'b0;
      r_halt_pend   <= 1'b0;
      r_halted      <= 1'b0;
      r_flush       <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_branch_pend <= w_branch_pend_nxt;
      r_halt_pend   <= w_halt_pend_nxt;
      r_halted      <= w_halted_nxt;
      r_flush       <= w_flush_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
    end
  end

  assign o_issue     = w_issue;
  assign o_stall     = w_stall;
  assign o_flush     = r_flush;
  assign o_halted    = r_halted;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Bench for mips32_hazard_ctrl: two instances (WB bypass with 16-bit counter,
// no bypass with 4-bit counter) share stimulus. A per-register "busy until
// cycle" scoreboard model checks both every cycle; a vector table and a few
// hand-written sequences pin down exact expected values for instance 0.
module tb_mips32_hazard_ctrl;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n, id_valid, use_rs, use_rt, wr_en, is_br, is_hlt, br_res, br_tkn;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        issue0, stall0, flush0, halted0;
  logic        issue1, stall1, flush1, halted1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  mips32_hazard_ctrl #(.PIPE_DEPTH(3), .WB_BYPASS(1), .CNT_W(16)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_wr_en(wr_en), .i_id_rd(id_rd),
    .i_id_is_branch(is_br), .i_id_is_halt(is_hlt), .i_br_resolve(br_res),
    .i_br_taken(br_tkn), .o_issue(issue0), .o_stall(stall0), .o_flush(flush0),
    .o_halted(halted0), .o_stall_cnt(cnt0)
  );

  mips32_hazard_ctrl #(.PIPE_DEPTH(3), .WB_BYPASS(0), .CNT_W(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_wr_en(wr_en), .i_id_rd(id_rd),
    .i_id_is_branch(is_br), .i_id_is_halt(is_hlt), .i_br_resolve(br_res),
    .i_br_taken(br_tkn), .o_issue(issue1), .o_stall(stall1), .o_flush(flush1),
    .o_halted(halted1), .o_stall_cnt(cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model: per-register busy-until scoreboard -----
  int busy_m [2][32];
  int lastwr_m [2];
  bit bp_m [2], hp_m [2], hd_m [2], fl_m [2];
  int cnt_m [2];
  int wbp [2]  = '{1, 0};
  int cmax [2] = '{65535, 15};
  int cyc = 0;

  task automatic m_reset(input int k);
    for (int r = 0; r < 32; r++) busy_m[k][r] = -1000;
    lastwr_m[k] = -1000;
    bp_m[k] = 0; hp_m[k] = 0; hd_m[k] = 0; fl_m[k] = 0; cnt_m[k] = 0;
  endtask

  function automatic bit m_issue(input int k);
    bit haz;
    haz = (use_rs && id_rs != 0 && busy_m[k][id_rs] >= cyc) ||
          (use_rt && id_rt != 0 && busy_m[k][id_rt] >= cyc);
    return rst_n && id_valid && !haz && !bp_m[k] && !hp_m[k] && !hd_m[k] && !fl_m[k];
  endfunction

  task automatic model_check();
    bit ei, es;
    for (int k = 0; k < 2; k++) begin
      ei = m_issue(k);
      es = rst_n && id_valid && !ei;
      chk($sformatf("u%0d.issue", k), int'(k == 0 ? issue0 : issue1), int'(ei));
      chk($sformatf("u%0d.stall", k), int'(k == 0 ? stall0 : stall1), int'(es));
      chk($sformatf("u%0d.flush", k), int'(k == 0 ? flush0 : flush1), int'(fl_m[k]));
      chk($sformatf("u%0d.halted", k), int'(k == 0 ? halted0 : halted1), int'(hd_m[k]));
      chk($sformatf("u%0d.stall_cnt", k), k == 0 ? int'(cnt0) : int'(cnt1), cnt_m[k]);
    end
  endtask

  task automatic model_update();
    bit iss, stl, hd_n, fl_n, bp_n, hp_n;
    for (int k = 0; k < 2; k++) begin
      iss = m_issue(k);
      stl = rst_n && id_valid && !iss;
      if (!rst_n) begin
        m_reset(k);
      end else begin
        hd_n = hd_m[k] || (hp_m[k] && cyc > lastwr_m[k] + D);
        fl_n = br_res && br_tkn && bp_m[k];
        bp_n = (bp_m[k] && !br_res) || (iss && is_br);
        hp_n = hp_m[k] || (iss && is_hlt);
        if (iss && wr_en && id_rd != 0) begin
          busy_m[k][id_rd] = cyc + D - wbp[k];
          lastwr_m[k] = cyc;
        end
        if (stl && cnt_m[k] < cmax[k]) cnt_m[k]++;
        hd_m[k] = hd_n; fl_m[k] = fl_n; bp_m[k] = bp_n; hp_m[k] = hp_n;
      end
    end
    cyc++;
  endtask

  task automatic tick_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input int rs, input bit urs, input int rt,
                       input bit urt, input bit w, input int rd, input bit br, input bit hl,
                       input bit res, input bit tk);
    rst_n = r; id_valid = v; id_rs = 5'(rs); use_rs = urs; id_rt = 5'(rt); use_rt = urt;
    wr_en = w; id_rd = 5'(rd); is_br = br; is_hlt = hl; br_res = res; br_tkn = tk;
  endtask

  // ---------------- vector table ---------------------------------------------
  typedef struct {
    bit r, v; int rs; bit urs; int rt; bit urt; bit w; int rd; bit br, hl, res, tk;
    bit e_iss, e_stl, e_fl, e_hd; int e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, bit v, int rs, bit urs, int rt, bit urt, bit w, int rd,
                              bit br, bit hl, bit res, bit tk,
                              bit ei, bit es, bit ef, bit eh, int ec);
    vec_t x;
    x.r = r; x.v = v; x.rs = rs; x.urs = urs; x.rt = rt; x.urt = urt; x.w = w; x.rd = rd;
    x.br = br; x.hl = hl; x.res = res; x.tk = tk;
    x.e_iss = ei; x.e_stl = es; x.e_fl = ef; x.e_hd = eh; x.e_cnt = ec;
    return x;
  endfunction

  int waited;

  initial begin
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) m_reset(k);
    tick_pos();

    //            r v rs u rt u w rd br hl rs tk | iss stl fl hd cnt
    vq.push_back(mk(0,1, 0,0, 0,0,0, 0, 0,0,0,0,   0,0,0,0,0));  // reset held
    vq.push_back(mk(1,1, 0,1, 0,0,1, 1, 0,0,0,0,   1,0,0,0,0));  // ADDI R1,R0,120
    vq.push_back(mk(1,1, 1,1, 0,0,1, 2, 0,0,0,0,   0,1,0,0,0));  // LW R2,0(R1)
    vq.push_back(mk(1,1, 1,1, 0,0,1, 2, 0,0,0,0,   0,1,0,0,1));
    vq.push_back(mk(1,1, 1,1, 0,0,1, 2, 0,0,0,0,   1,0,0,0,2));
    for (int k = 0; k < 4; k++)                                   // independent ORs
      vq.push_back(mk(1,1, 10+k,1, 14,1,1, 20+k, 0,0,0,0, 1,0,0,0,2));
    vq.push_back(mk(1,1,15,1, 0,0,1, 0, 0,0,0,0,   1,0,0,0,2));  // write R0
    vq.push_back(mk(1,1, 0,1, 0,1,1,24, 0,0,0,0,   1,0,0,0,2));  // read R0
    vq.push_back(mk(1,1,25,1, 0,0,0, 0, 1,0,0,0,   1,0,0,0,2));  // BEQZ
    vq.push_back(mk(1,1,26,1, 0,0,1,27, 0,0,0,0,   0,1,0,0,2));
    vq.push_back(mk(1,1,26,1, 0,0,1,27, 0,0,1,1,   0,1,0,0,3));  // resolve taken
    vq.push_back(mk(1,1,26,1, 0,0,1,27, 0,0,0,0,   0,1,1,0,4));  // flush cycle
    vq.push_back(mk(1,1,26,1, 0,0,1,27, 0,0,0,0,   1,0,0,0,5));
    vq.push_back(mk(1,1,25,1, 0,0,0, 0, 1,0,0,0,   1,0,0,0,5));  // BEQZ
    vq.push_back(mk(1,1,26,1, 0,0,1,28, 0,0,0,0,   0,1,0,0,5));
    vq.push_back(mk(1,1,26,1, 0,0,1,28, 0,0,1,0,   0,1,0,0,6));  // resolve not taken
    vq.push_back(mk(1,1,26,1, 0,0,1,28, 0,0,0,0,   1,0,0,0,7));
    vq.push_back(mk(1,1,29,1, 0,0,1,30, 0,0,1,1,   1,0,0,0,7));  // stray resolve
    vq.push_back(mk(1,1,29,1, 0,0,1,31, 0,0,0,0,   1,0,0,0,7));
    vq.push_back(mk(1,0, 0,0, 0,0,0, 0, 0,0,0,0,   0,0,0,0,7));  // bubble

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].v, vq[i].rs, vq[i].urs, vq[i].rt, vq[i].urt, vq[i].w, vq[i].rd,
            vq[i].br, vq[i].hl, vq[i].res, vq[i].tk);
      tick_neg();
      chk($sformatf("vec%0d.issue", i), int'(issue0), int'(vq[i].e_iss));
      chk($sformatf("vec%0d.stall", i), int'(stall0), int'(vq[i].e_stl));
      chk($sformatf("vec%0d.flush", i), int'(flush0), int'(vq[i].e_fl));
      chk($sformatf("vec%0d.halted", i), int'(halted0), int'(vq[i].e_hd));
      chk($sformatf("vec%0d.stall_cnt", i), int'(cnt0), vq[i].e_cnt);
      tick_pos();
    end

    // ---- HLT drain: ADDI, HLT, then a younger op that must never issue ----
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick_neg(); tick_pos();
    drive(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); tick_neg();
    chk("halt.addi_issue", int'(issue0), 1); tick_pos();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick_neg();
    chk("halt.hlt_issue", int'(issue0), 1); tick_pos();
    drive(1, 1, 9, 1, 0, 0, 1, 9, 0, 0, 0, 0);
    waited = 0;
    while (!halted0 && waited < 8) begin
      tick_neg(); tick_pos(); waited++;
    end
    chk("halt.latency", waited, 3);
    for (int i = 0; i < 20; i++) begin
      tick_neg();
      chk("halt.sticky", int'(halted0), 1);
      chk("halt.no_issue", int'(issue0), 0);
      tick_pos();
    end

    // ---- reset while a stall and a pending branch are active ----
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick_neg(); tick_pos();
    drive(1, 1, 25, 1, 0, 0, 0, 0, 1, 0, 0, 0); tick_neg();
    chk("rst.br_issue", int'(issue0), 1); tick_pos();
    drive(1, 1, 26, 1, 0, 0, 1, 27, 0, 0, 0, 0); tick_neg();
    chk("rst.stall_before", int'(stall0), 1); tick_pos();
    drive(0, 1, 26, 1, 0, 0, 1, 27, 0, 0, 0, 0); tick_neg();
    chk("rst.issue_held", int'(issue0), 0);
    chk("rst.stall_held", int'(stall0), 0); tick_pos();
    drive(1, 1, 26, 1, 0, 0, 1, 27, 0, 0, 0, 0); tick_neg();
    chk("rst.issue_after", int'(issue0), 1);
    chk("rst.cnt_after", int'(cnt0), 0);
    chk("rst.cnt1_after", int'(cnt1), 0); tick_pos();

    // ---- no WB bypass: dependent op stalls three cycles ----
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick_neg(); tick_pos();
    drive(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); tick_neg();
    chk("nobyp.addi", int'(issue1), 1); tick_pos();
    drive(1, 1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick_neg();
      chk($sformatf("nobyp.lw%0d", i), int'(issue1), i == 3 ? 1 : 0);
      tick_pos();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick_neg();
    chk("nobyp.cnt", int'(cnt1), 3); tick_pos();

    // ---- randomized traffic against the scoreboard model ----
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) != 0, $urandom_range(7) != 0,
            $urandom_range(7), $urandom_range(1), $urandom_range(7), $urandom_range(1),
            $urandom_range(1), $urandom_range(7), $urandom_range(9) == 0,
            $urandom_range(39) == 0, $urandom_range(3) == 0, $urandom_range(1));
      tick_neg();
      tick_pos();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
